// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scan encoder and its downstream consumers.
// Key codes are indexed {row, col} so the encoder can look them up directly.
package keypad_pkg;

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StPressed,
        StRelease
    } state_e;

    // * clears and # enters in the accumulator/display stages
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    // Nibble i holds the code for index i = {row, col}; nibble 0 is row 0, col 0
    localparam logic [63:0] KEY_MAP = {4'hD, KEY_HASH, 4'h0, KEY_STAR, 48'hC987_B654_A321};

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [5:0] base;
        base = {row, col, 2'b00};
        return KEY_MAP[base +: 4];
    endfunction

    // Lowest-index active-low row wins when several rows are low
    function automatic logic [1:0] low_row(input logic [3:0] rows);
        if (!rows[0]) begin
            return 2'd0;
        end else if (!rows[1]) begin
            return 2'd1;
        end else if (!rows[2]) begin
            return 2'd2;
        end
        return 2'd3;
    endfunction

endpackage

// File: rtl/keypad_scan_encoder_if.sv
// Keypad pins plus the key output bus that feeds the digit accumulator.
interface keypad_scan_encoder_if;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  row_in,
        output col_out,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output row_in,
        input  col_out,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for the 4 keypad rows; resets to all-ones (no key down).
module sync2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] d_i,
    output logic [3:0] q_o
);
    logic [3:0] meta_q;
    logic [3:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 4'hF;
            sync_q <= 4'hF;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/keypad_scan_encoder.sv
// 4x4 keypad scanner: drives one column low at a time, debounces press and release,
// and emits one key_valid pulse with the encoded nibble per physical press.
module keypad_scan_encoder
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CNT = 250000
) (
    input logic                   clk,
    input logic                   rst,
    keypad_scan_encoder_if.master kp
);
    localparam int unsigned MaxCnt = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
    localparam int unsigned CntW   = $clog2(MaxCnt) + 1;
    localparam logic [CntW-1:0] ScanLast = CntW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0] DebTop   = CntW'(DEBOUNCE_CNT);

    logic [3:0] rs;

    sync2 u_sync2 (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (kp.row_in),
        .q_o   (rs)
    );

    state_e          state_q, state_d;
    logic [1:0]      col_q, col_d;
    logic [1:0]      row_q, row_d;
    logic [3:0]      pat_q, pat_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]      code_q, code_d;
    logic            valid_q, valid_d;
    logic            held_q, held_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StScan;
            col_q   <= 2'd0;
            row_q   <= 2'd0;
            pat_q   <= 4'hF;
            cnt_q   <= '0;
            code_q  <= 4'h0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        valid_d = 1'b0;
        held_d  = held_q;
        cnt_inc = cnt_q + 1'b1;

        unique case (state_q)
            StScan: begin
                if (cnt_q == ScanLast) begin
                    cnt_d = '0;
                    if (rs == 4'hF) begin
                        col_d = col_q + 2'd1;
                    end else begin
                        row_d   = low_row(rs);
                        pat_d   = rs;
                        state_d = StDebounce;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StDebounce: begin
                // Any change from the entry pattern, including release, abandons the attempt
                if (rs != pat_q) begin
                    state_d = StScan;
                    col_d   = col_q + 2'd1;
                    cnt_d   = '0;
                end else if (cnt_inc == DebTop) begin
                    code_d  = key_map(row_q, col_q);
                    valid_d = 1'b1;
                    held_d  = 1'b1;
                    state_d = StPressed;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StPressed: begin
                if (rs == 4'hF) begin
                    state_d = StRelease;
                    cnt_d   = '0;
                end
            end
            StRelease: begin
                if (rs != 4'hF) begin
                    cnt_d = '0;
                end else if (cnt_inc == DebTop) begin
                    held_d  = 1'b0;
                    state_d = StScan;
                    col_d   = col_q + 2'd1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = StScan;
        endcase
    end

    assign kp.col_out   = ~(4'b0001 << col_q);
    assign kp.key_code  = code_q;
    assign kp.key_valid = valid_q;
    assign kp.key_held  = held_q;
endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Bench for keypad_scan_encoder: a switch-matrix keypad model, a pulse monitor feeding
// a nibble accumulator, and a code table by row/column as the reference.
module tb_keypad_scan_encoder;
    localparam int unsigned ScanDiv = 4;
    localparam int unsigned DebCnt  = 8;
    localparam int          PressBudget = 2 + 4 * ScanDiv + DebCnt + 4;

    localparam logic [3:0] RefMap [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] keys = '0;
    logic [3:0]  row_drv;
    logic        acc_clr = 1'b0;
    logic [15:0] acc = '0;
    int          pulses = 0;
    int          vectors = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    keypad_scan_encoder_if kp ();

    keypad_scan_encoder #(
        .SCAN_DIV     (ScanDiv),
        .DEBOUNCE_CNT (DebCnt)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    // Switch matrix: a closed key at (r,c) pulls row r low only while column c is driven
    always_comb begin
        row_drv = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !kp.col_out[c]) row_drv[r] = 1'b0;
            end
        end
    end
    assign kp.row_in = row_drv;

    always @(negedge clk) begin
        if (acc_clr) acc <= '0;
        else if (kp.key_valid) acc <= {acc[11:0], kp.key_code};
        if (kp.key_valid) pulses <= pulses + 1;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse(input int base, output bit got);
        got = 1'b0;
        for (int i = 0; i < PressBudget; i++) begin
            @(posedge clk);
            #1;
            if (pulses > base) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    // Cycles from now until key_held falls; -1 if it never does within the budget
    task automatic wait_held_low(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (!kp.key_held) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        keys = '0;
        cycles(3);
        vectors++;
        if (kp.col_out !== 4'b1110) begin
            errors++;
            $display("FAIL reset_col: got %b want 1110", kp.col_out);
        end
        vectors++;
        if (kp.key_code !== 4'h0 || kp.key_valid !== 1'b0 || kp.key_held !== 1'b0) begin
            errors++;
            $display("FAIL reset_outs: code=%h valid=%b held=%b want 0/0/0",
                     kp.key_code, kp.key_valid, kp.key_held);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5 * 4 * ScanDiv; k++) begin
            logic [3:0] want;
            want = ~(4'b0001 << ((k / ScanDiv) % 4));
            vectors++;
            if (kp.col_out !== want || kp.key_valid !== 1'b0 || kp.key_code !== 4'h0) begin
                errors++;
                $display("FAIL idle_scan k=%0d: col=%b valid=%b code=%h want col=%b valid=0 code=0",
                         k, kp.col_out, kp.key_valid, kp.key_code, want);
            end
            @(negedge clk);
        end
        #1;
    endtask

    // Press (r,c) until accepted, check the code and hold; caller handles release
    task automatic press_and_check(input int r, input int c, input string name, output int base);
        bit got;
        base = pulses;
        keys[r*4+c] = 1'b1;
        wait_pulse(base, got);
        vectors++;
        if (!got) begin
            errors++;
            $display("FAIL %s_pulse: no key_valid within %0d cycles", name, PressBudget);
        end
        vectors++;
        if (kp.key_code !== RefMap[r][c] || kp.key_held !== 1'b1) begin
            errors++;
            $display("FAIL %s_code: code=%h held=%b want code=%h held=1",
                     name, kp.key_code, kp.key_held, RefMap[r][c]);
        end
    endtask

    task automatic check_release(input int base, input int lo, input int hi, input string name);
        int n;
        wait_held_low(n);
        vectors++;
        if (n < lo || n > hi) begin
            errors++;
            $display("FAIL %s_held_drop: held fell after %0d cycles want %0d..%0d",
                     name, n, lo, hi);
        end
        cycles(4);
        vectors++;
        if (pulses !== base + 1) begin
            errors++;
            $display("FAIL %s_pulse_count: got %0d pulses want %0d", name, pulses - base, 1);
        end
    endtask

    task automatic test_press;
        int base;
        press_and_check(1, 2, "press_6", base);
        cycles(40 - PressBudget / 2);
        keys = '0;
        check_release(base, DebCnt, DebCnt + 4, "press_6");
    endtask

    task automatic test_bounce_press;
        int base;
        base = pulses;
        keys[2*4+0] = 1'b1;
        cycles(3);
        keys[2*4+0] = 1'b0;
        cycles(1);
        press_and_check(2, 0, "bounce_7", base);
        base = base;
        cycles(10);
        keys = '0;
        check_release(base, DebCnt, DebCnt + 4, "bounce_7");
    endtask

    task automatic test_release_bounce;
        int base;
        press_and_check(3, 1, "relbounce_0", base);
        cycles(6);
        keys = '0;
        cycles(5);
        keys[3*4+1] = 1'b1;
        cycles(1);
        keys = '0;
        vectors++;
        if (kp.key_held !== 1'b1) begin
            errors++;
            $display("FAIL relbounce_held_mid: held=%b want 1", kp.key_held);
        end
        check_release(base, DebCnt, DebCnt + 4, "relbounce_0");
    endtask

    task automatic test_multi_row_and_acc;
        int base;
        keys[0*4+3] = 1'b1;
        keys[3*4+3] = 1'b1;
        press_and_check(0, 3, "multirow_A", base);
        cycles(5);
        keys = '0;
        check_release(base, DebCnt, DebCnt + 4, "multirow_A");
        acc_clr = 1'b1;
        cycles(1);
        acc_clr = 1'b0;
        for (int c = 0; c < 3; c++) begin
            press_and_check(0, c, "acc_digit", base);
            cycles(3);
            keys = '0;
            check_release(base, DebCnt, DebCnt + 4, "acc_digit");
        end
        vectors++;
        if (acc !== 16'h0123) begin
            errors++;
            $display("FAIL accumulator: got %h want 0123", acc);
        end
    endtask

    task automatic test_reset_mid;
        int  base;
        int  n;
        bit  seen;
        seen = 1'b0;
        keys = '0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cycles(1);
            if (kp.col_out != 4'b1011) seen = 1'b1;
        end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cycles(1);
            if (kp.col_out == 4'b1011) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            errors++;
            $display("FAIL rstmid_col_wait: column 2 never driven, col=%b", kp.col_out);
        end
        base = pulses;
        keys[2*4+2] = 1'b1;
        cycles(6);
        rst = 1'b1;
        cycles(1);
        vectors++;
        if (kp.col_out !== 4'b1110 || kp.key_held !== 1'b0 || kp.key_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_abort: col=%b held=%b valid=%b want 1110/0/0",
                     kp.col_out, kp.key_held, kp.key_valid);
        end
        rst = 1'b0;
        vectors++;
        if (pulses !== base) begin
            errors++;
            $display("FAIL rstmid_no_pulse: got %0d pulses want 0", pulses - base);
        end
        press_and_check(2, 2, "rstmid_9", n);
        cycles(5);
        keys = '0;
        check_release(base, DebCnt, DebCnt + 4, "rstmid_9");
    endtask

    // Random key plus an ignored second key on another column while the first is held
    task automatic test_random;
        for (int it = 0; it < 8; it++) begin
            int r, c, r2, c2, base;
            r  = $urandom_range(3, 0);
            c  = $urandom_range(3, 0);
            r2 = $urandom_range(3, 0);
            c2 = (c + 1 + $urandom_range(2, 0)) % 4;
            press_and_check(r, c, "random", base);
            cycles($urandom_range(6, 2));
            if (it % 2 == 1) keys[r2*4+c2] = 1'b1;
            cycles($urandom_range(20, 5));
            vectors++;
            if (kp.key_code !== RefMap[r][c] || pulses !== base + 1) begin
                errors++;
                $display("FAIL random_hold r=%0d c=%0d: code=%h pulses=%0d want code=%h pulses=1",
                         r, c, kp.key_code, pulses - base, RefMap[r][c]);
            end
            keys = '0;
            check_release(base, DebCnt, DebCnt + 4, "random");
            cycles($urandom_range(5, 0));
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce_press();
        test_release_bounce();
        test_multi_row_and_acc();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/keypad_scan_encoder.md
Name: keypad_scan_encoder

Overview:
- Scans a 4x4 matrix keypad on DE10-Lite GPIO, debounces press and release, and encodes each key to a 4-bit nibble.
- Emits exactly one `key_valid` pulse per physical press.
- Sits directly upstream of the shift-left-by-4 digit accumulator; `key_code` feeds its nibble input, `key_valid` qualifies the shift/add.

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven before rows are sampled (settle time); minimum 2.
- DEBOUNCE_CNT, 250000: consecutive stable cycles needed to accept a press or a release; minimum 1.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- row_in  in  4  keypad rows, active-low, externally pulled up; asynchronous to clk.
- col_out  out  4  keypad column drive, active-low, exactly one bit low at all times.
- key_code  out  4  encoded nibble of last accepted key; held until next accept.
- key_valid  out  1  one-cycle pulse when `key_code` is updated.
- key_held  out  1  high from accept until release debounce completes.

Behaviour:
- Clock/reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Synchronizer: `row_in` passes through a 2-flop synchronizer (reset value 4'hF); all FSM decisions use the synchronized value `rs`.
- Reset values: col_out=4'b1110 (col 0), key_code=4'h0, key_valid=0, key_held=0; FSM=SCAN, col index=0, counters=0.
- SCAN state:
  - Drive column c low (col_out = ~(1<<c)) and count 0..SCAN_DIV-1.
  - At count SCAN_DIV-1: if rs==4'hF, advance c (3 wraps to 0) and clear the count.
  - Otherwise latch c and r, where r = lowest-index low row (priority when several rows are low), then go to DEBOUNCE.
- DEBOUNCE state:
  - Column held. Counter increments each cycle while rs equals the pattern latched at entry.
  - Any mismatch (including rs back to 4'hF): abandon, no pulse, return to SCAN at c+1.
  - On reaching DEBOUNCE_CNT matching cycles: key_code <= map(r,c), key_valid=1 for exactly that one cycle, key_held=1, go to PRESSED.
- PRESSED state: column held. When rs==4'hF, go to RELEASE with counter cleared.
- RELEASE state:
  - Counter increments while rs==4'hF; any low row clears the counter and stays in RELEASE. Bounce never re-emits a pulse.
  - At DEBOUNCE_CNT: key_held=0, go to SCAN at c+1.
- Press latency: key_valid asserts 2 (sync) + ≤4·SCAN_DIV + DEBOUNCE_CNT + 1 cycles after row_in goes low and stays low.
- Second key while one is held: ignored; only one key is tracked at a time.
- Reset mid-operation: abort immediately to the reset state, no pulse. A key still down after reset is re-detected and emits once.
- Key map (row r, col c → code):
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: *→E, 0→0, #→F, D→D
- Counters sized $clog2(max param)+1; no overflow is reachable.

Decomposition:
- Shared package `keypad_pkg`:
  - FSM state enum: SCAN, DEBOUNCE, PRESSED, RELEASE.
  - 16-entry key map constant indexed {r,c}.
  - Code constants KEY_STAR=4'hE and KEY_HASH=4'hF. The accumulator and display stages use these to treat * as clear and # as enter.
- Sub-module `sync2`: a 4-bit 2-flop synchronizer with synchronous reset to all-ones.
- FSM, counters and encoder stay in the top module.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=8; keypad model pulls row r low only while col_out[c]==0):
- Reset with no key → col_out cycles 1110→1101→1011→0111→1110, each held 4 cycles; key_valid never asserts; key_code=0.
- Press r1,c2 held 40 cycles → exactly one key_valid pulse with key_code=4'h6; key_held high until 8 cycles after release.
- Press r2,c0 with 3-cycle bounce (low 3, high 1, then low steady) → abandoned attempt emits nothing; single pulse with key_code=4'h7 later.
- Release bounce on r3,c1 (key_code=4'h0): rows high 5, low 1, high steady → no second pulse; key_held drops 8 cycles after the final high.
- r0 and r3 low together on c3 → key_code=4'hA (lowest row wins); feed pulses "1","2","3" into the accumulator → accumulator reads 16'h0123 (after load).
- rst asserted during DEBOUNCE → next cycle col_out=1110, key_held=0, no pulse. Key still down → exactly one pulse after re-detection.
